// File: rtl/sumres_pkg.sv
// rtl/sumres_pkg.sv - shared types, widths and nibble drive helper for the add/sub sequencer
package sumres_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam int NIB_W = 4;

  // The stage inverts B when Cin=1, so pre-invert to make it add beff+k either way.
  function automatic logic [NIB_W-1:0] nib_drive(input logic [NIB_W-1:0] beff, input logic k);
    return k ? ~beff : beff;
  endfunction

endpackage

// File: rtl/SumadorRestador4bits.sv
// rtl/SumadorRestador4bits.sv - combinational 4-bit adder/subtractor stage (Cin=1 selects A-B)
module SumadorRestador4bits (
  input  logic A3,
  input  logic A2,
  input  logic A1,
  input  logic A0,
  input  logic B3,
  input  logic B2,
  input  logic B1,
  input  logic B0,
  input  logic Cin,
  output logic S3,
  output logic S2,
  output logic S1,
  output logic S0,
  output logic Cout
);

  logic [3:0] a;
  logic [3:0] b_sel;
  logic [4:0] sum;

  assign a     = {A3, A2, A1, A0};
  assign b_sel = Cin ? ~{B3, B2, B1, B0} : {B3, B2, B1, B0};
  assign sum   = {1'b0, a} + {1'b0, b_sel} + {4'b0000, Cin};

  assign {S3, S2, S1, S0} = sum[3:0];
  assign Cout             = sum[4];

endmodule

// File: rtl/flags_sumres.sv
// rtl/flags_sumres.sv - signed overflow and zero detection for the assembled result
module flags_sumres #(
  parameter int W = 8
) (
  input  logic         a_msb,
  input  logic         beff_msb,
  input  logic [W-1:0] res,
  output logic         ovf,
  output logic         zero
);

  assign ovf  = (a_msb == beff_msb) && (res[W-1] != a_msb);
  assign zero = (res == '0);

endmodule

// File: rtl/secuenciador_sumres.sv
// rtl/secuenciador_sumres.sv - sequences a W-bit add/sub through an external 4-bit stage, LSN first
module secuenciador_sumres
  import sumres_pkg::*;
#(
  parameter int NIBBLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NIB_W*NIBBLES-1:0] in_a,
  input  logic [NIB_W*NIBBLES-1:0] in_b,
  input  logic                     in_sub,
  output logic [NIB_W-1:0]         nib_a,
  output logic [NIB_W-1:0]         nib_b,
  output logic                     nib_cin,
  input  logic [NIB_W-1:0]         nib_s,
  input  logic                     nib_cout,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NIB_W*NIBBLES-1:0] out_res,
  output logic                     out_carry,
  output logic                     out_ovf,
  output logic                     out_zero
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int CNT_W = (NIBBLES > 2) ? 2 : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               k_q, k_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       beff_q, beff_d;
  logic [W-1:0]       acc_q, acc_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [NIB_W-1:0]   nib_a_q, nib_a_d;
  logic [NIB_W-1:0]   nib_b_q, nib_b_d;
  logic               nib_cin_q, nib_cin_d;
  logic [W-1:0]       out_res_q, out_res_d;
  logic               out_carry_q, out_carry_d;
  logic               out_ovf_q, out_ovf_d;
  logic               out_zero_q, out_zero_d;

  logic [W-1:0]       acc_nxt;
  logic [W-1:0]       a_sh;
  logic [W-1:0]       beff_sh;
  logic [W-1:0]       beff_in;
  logic               flag_ovf;
  logic               flag_zero;

  // Accumulator is cleared on accept, so OR-ing in the current nibble is enough.
  assign acc_nxt = acc_q | (W'(nib_s) << (NIB_W * int'(cnt_q)));
  assign beff_in = in_sub ? ~in_b : in_b;

  flags_sumres #(.W(W)) u_flags (
    .a_msb    (a_q[W-1]),
    .beff_msb (beff_q[W-1]),
    .res      (acc_nxt),
    .ovf      (flag_ovf),
    .zero     (flag_zero)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    k_d         = k_q;
    a_d         = a_q;
    beff_d      = beff_q;
    acc_d       = acc_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    nib_a_d     = nib_a_q;
    nib_b_d     = nib_b_q;
    nib_cin_d   = nib_cin_q;
    out_res_d   = out_res_q;
    out_carry_d = out_carry_q;
    out_ovf_d   = out_ovf_q;
    out_zero_d  = out_zero_q;
    a_sh        = '0;
    beff_sh     = '0;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = in_a;
          beff_d     = beff_in;
          k_d        = in_sub;
          cnt_d      = '0;
          acc_d      = '0;
          nib_a_d    = in_a[NIB_W-1:0];
          nib_b_d    = nib_drive(beff_in[NIB_W-1:0], in_sub);
          nib_cin_d  = in_sub;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        acc_d = acc_nxt;
        k_d   = nib_cout;
        if (cnt_q == CNT_W'(NIBBLES - 1)) begin
          out_res_d   = acc_nxt;
          out_carry_d = nib_cout;
          out_ovf_d   = flag_ovf;
          out_zero_d  = flag_zero;
          out_valid_d = 1'b1;
          nib_a_d     = '0;
          nib_b_d     = '0;
          nib_cin_d   = 1'b0;
          state_d     = DONE;
        end else begin
          // Pre-load the drive for the next nibble so the stage sees it right after this edge.
          a_sh      = a_q >> (NIB_W * (int'(cnt_q) + 1));
          beff_sh   = beff_q >> (NIB_W * (int'(cnt_q) + 1));
          cnt_d     = cnt_q + 1'b1;
          nib_a_d   = a_sh[NIB_W-1:0];
          nib_b_d   = nib_drive(beff_sh[NIB_W-1:0], nib_cout);
          nib_cin_d = nib_cout;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      k_q         <= 1'b0;
      a_q         <= '0;
      beff_q      <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      nib_a_q     <= '0;
      nib_b_q     <= '0;
      nib_cin_q   <= 1'b0;
      out_res_q   <= '0;
      out_carry_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      k_q         <= k_d;
      a_q         <= a_d;
      beff_q      <= beff_d;
      acc_q       <= acc_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      nib_a_q     <= nib_a_d;
      nib_b_q     <= nib_b_d;
      nib_cin_q   <= nib_cin_d;
      out_res_q   <= out_res_d;
      out_carry_q <= out_carry_d;
      out_ovf_q   <= out_ovf_d;
      out_zero_q  <= out_zero_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign nib_a     = nib_a_q;
  assign nib_b     = nib_b_q;
  assign nib_cin   = nib_cin_q;
  assign out_res   = out_res_q;
  assign out_carry = out_carry_q;
  assign out_ovf   = out_ovf_q;
  assign out_zero  = out_zero_q;

endmodule
